// File: rtl/gau_pair_sequencer.sv
// Pairs each gate sample of a conv frame with its buffered feature sample and
// presents the (feat, gate) pair to the gated activation unit through a one-slot output register.
module gau_pair_sequencer #(
  parameter int N_CH = 4,
  localparam int CW = $clog2(N_CH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [15:0]   in_data,
  input  logic          in_valid,
  input  logic          in_last,
  output logic          in_ready,
  output logic [15:0]   out_feat,
  output logic [15:0]   out_gate,
  output logic [CW-1:0] out_ch,
  output logic          out_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          err
);

  localparam int DATA_W = 16;
  localparam logic [CW-1:0] LAST_CH = CW'(N_CH - 1);

  typedef enum logic {FILL, PAIR} state_e;

  state_e                   state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic signed [DATA_W-1:0] feat_buf_q [N_CH];
  logic signed [DATA_W-1:0] feat_q, gate_q;
  logic [CW-1:0]            ch_q;
  logic                     last_q, valid_q, err_q;

  logic accept, cnt_at_last, frame_end;

  assign cnt_at_last = (cnt_q == LAST_CH);
  assign frame_end   = (state_q == PAIR) && cnt_at_last;
  // Feature filling never touches the output slot, so it proceeds even while the slot is stalled.
  assign in_ready    = (state_q == FILL) || !valid_q || out_ready;
  assign accept      = in_valid && in_ready;

  always_comb begin
    cnt_d   = cnt_q;
    state_d = state_q;
    if (accept) begin
      if (cnt_at_last) begin
        cnt_d   = '0;
        state_d = (state_q == FILL) ? PAIR : FILL;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      // An early frame marker resynchronises to the start of a new frame.
      if (in_last && !frame_end) begin
        cnt_d   = '0;
        state_d = FILL;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      feat_q  <= '0;
      gate_q  <= '0;
      ch_q    <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (valid_q && out_ready) begin
        valid_q <= 1'b0;
      end
      if (accept && (state_q == PAIR)) begin
        feat_q  <= feat_buf_q[cnt_q];
        gate_q  <= signed'(in_data);
        ch_q    <= cnt_q;
        last_q  <= cnt_at_last;
        valid_q <= 1'b1;
      end
      if (accept && (in_last != frame_end)) begin
        err_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept && (state_q == FILL)) begin
      feat_buf_q[cnt_q] <= signed'(in_data);
    end
  end

  assign out_feat  = feat_q;
  assign out_gate  = gate_q;
  assign out_ch    = ch_q;
  assign out_last  = last_q;
  assign out_valid = valid_q;
  assign err       = err_q;

endmodule

// File: doc/gau_pair_sequencer.md
Name: gau_pair_sequencer

Overview:
- Streaming stage directly upstream of the Q15 gated activation unit (GAU).
- Input is one conv-output time step per frame of 2*N_CH Q15 samples: N_CH feature channels first, then N_CH gate channels.
- Buffers the feature half, then pairs each arriving gate sample with its stored feature.
- Emits (feat, gate) pairs through a registered valid/ready output that drives the GAU in_feat/in_gate inputs.

Parameters:
N_CH, 4, number of feature channels; equals number of gate channels; must be >= 2
CW, $clog2(N_CH), channel index width (derived, not overridden)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
in_data  input  16  signed Q15 sample from conv stage
in_valid  input  1  in_data valid
in_last  input  1  marks final sample (gate N_CH-1) of a frame
in_ready  output  1  sequencer accepts in_data this cycle
out_feat  output  16  signed Q15 feature to GAU in_feat
out_gate  output  16  signed Q15 gate to GAU in_gate
out_ch  output  CW  channel index of current pair
out_last  output  1  pair is channel N_CH-1
out_valid  output  1  pair valid
out_ready  input  1  downstream accepts pair
err  output  1  sticky frame-framing error

Behaviour:
- Clocking: all state updates on the rising edge of clk. Reset is synchronous, active-high, checked first.
- Reset values: state=FILL, cnt=0, out_valid=0, out_feat=0, out_gate=0, out_ch=0, out_last=0, err=0. The feature buffer (N_CH x 16 register array) is not cleared.
- Input accept condition: in_valid && in_ready.
- Output register:
  - Cleared (out_valid<=0) on out_valid && out_ready, unless reloaded in the same cycle.
  - Holds all out_* values stable while out_valid && !out_ready.
- FSM state FILL:
  - in_ready=1 unconditionally. The output register may still be draining.
  - On accept: buf[cnt]<=in_data.
  - If cnt==N_CH-1: cnt<=0, go to PAIR. Otherwise cnt<=cnt+1.
- FSM state PAIR:
  - in_ready = !out_valid || out_ready (single output slot, no bubble).
  - On accept: out_feat<=buf[cnt], out_gate<=in_data, out_ch<=cnt, out_last<=(cnt==N_CH-1), out_valid<=1.
  - If cnt==N_CH-1: cnt<=0, go to FILL. Otherwise cnt<=cnt+1.
- Latency: gate sample accepted in cycle t gives out_valid=1 in cycle t+1.
- Throughput: 1 pair/cycle in PAIR with out_ready held high.
- No arithmetic: data passes bit-exact, no saturation or rescaling.
- Framing checks:
  - in_last is only meaningful on accept.
  - Early in_last (accepted sample not at frame position 2*N_CH-1):
    - err<=1.
    - The sample is still processed normally. If it lands in PAIR, the pair is emitted.
    - Then force cnt<=0, state<=FILL, i.e. resync to a new frame.
  - Missing in_last (accepted sample at position 2*N_CH-1 with in_last=0):
    - err<=1.
    - Normal transition to FILL.
  - err clears only on rst.
- Simultaneous events:
  - In PAIR, out_ready drain and new load in the same cycle gives load wins, out_valid stays 1.
  - A FILL accept while the output is stalled is allowed. Buffer writes never corrupt the held output, because out_feat is registered at load.
- Reset mid-operation: any partial frame is discarded, the pending output is dropped (out_valid=0), and the next accepted sample is treated as feature 0.

Test Plan:
- Nominal, N_CH=4, out_ready=1:
  - Stimulus: feats 0x4000, 0x7FFF, 0x2000, 0xC000, then gates 0x4000, 0x4000, 0xC000, 0x4000 with in_last on the 8th sample.
  - Required: four pairs (0x4000,0x4000), (0x7FFF,0x4000), (0x2000,0xC000), (0xC000,0x4000) on consecutive cycles; out_ch 0..3; out_last only on ch 3; each pair 1 cycle after its gate; err=0.
- Backpressure:
  - Stimulus: same frame, out_ready=0 for 3 cycles after the first pair.
  - Required: in_ready=0 and pair 0 held stable during the stall; no pair lost or duplicated after release.
- Early in_last:
  - Stimulus: in_last asserted on sample 6 (gate 1).
  - Required: pairs ch0 and ch1 emitted; err=1; the following well-formed frame pairs correctly from ch0; err remains 1.
- Missing in_last:
  - Stimulus: 8-sample frame with in_last=0 throughout.
  - Required: all 4 pairs emitted; err=1; next frame correct.
- Reset mid-PAIR:
  - Stimulus: assert rst for 1 cycle after 2 pairs, with out_valid=1 and out_ready=0.
  - Required: out_valid=0 the following cycle; state FILL; a new frame with feats 0x1000..0x4000 and gates 0x7FFF pairs correctly.
- Back-to-back frames:
  - Stimulus: two frames streamed continuously, in_valid=1, out_ready=1.
  - Required: 8 pairs total; FILL of frame 2 accepted at 1 sample/cycle immediately after frame 1's last gate; no gaps on the input side.
